// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 3-digit BCD converter
//
// Purpose: converts an unsigned WIDTH-bit value (WIDTH = 1..9, max 511)
// into hundreds/tens/units BCD digits. The conversion takes one clock per
// input bit. The result is held on the digit outputs until the next
// conversion completes.
//
// Ports:
//   CLK_50  in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   start   in   conversion request, accepted only while idle
//   bin     in   WIDTH-bit binary value, sampled on the accepting edge
//   busy    out  high while a conversion is in progress
//   done    out  one-cycle pulse: new result on bcd2/bcd1/bcd0
//   bcd2    out  hundreds digit of the last completed conversion
//   bcd1    out  tens digit
//   bcd0    out  units digit

module bin2bcd_seq #(
  parameter int WIDTH = 9
) (
  input  logic             CLK_50,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_CONV = 1'b1;

  // WIDTH never exceeds 9, so four counter bits are always enough.
  localparam logic [3:0] CNT_INIT = 4'(WIDTH);

  logic             state;
  logic [WIDTH-1:0] sh;
  logic [11:0]      scratch;
  logic [3:0]       cnt;

  logic [11:0]       adj;
  logic [WIDTH+11:0] shifted;
  logic [11:0]       next_scratch;
  logic [WIDTH-1:0]  next_sh;

  // One double-dabble step: correct each nibble independently (no carry
  // between nibbles), then shift the scratch/shift-register pair left by one.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted      = {adj, sh} << 1;
    next_scratch = shifted[WIDTH+11:WIDTH];
    next_sh      = shifted[WIDTH-1:0];
  end

  // busy depends only on the state register, so no input reaches an output
  // combinationally.
  assign busy = (state == S_CONV);

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      sh      <= '0;
      scratch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd2    <= 4'd0;
      bcd1    <= 4'd0;
      bcd0    <= 4'd0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          sh      <= bin;
          scratch <= '0;
          cnt     <= CNT_INIT;
          state   <= S_CONV;
        end
      end else begin
        scratch <= next_scratch;
        sh      <= next_sh;
        cnt     <= cnt - 4'd1;
        // The step taken with cnt == 1 is the last one; publish its result
        // directly from the next-state value so done and the digits align.
        if (cnt == 4'd1) begin
          state <= S_IDLE;
          done  <= 1'b1;
          bcd2  <= next_scratch[11:8];
          bcd1  <= next_scratch[7:4];
          bcd0  <= next_scratch[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq

module tb_bin2bcd_seq;

  logic       CLK_50;
  logic       RST_N;
  logic       start;
  logic [8:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bin2bcd_seq #(.WIDTH(9)) dut (
    .CLK_50 (CLK_50),
    .RST_N  (RST_N),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd2   (bcd2),
    .bcd1   (bcd1),
    .bcd0   (bcd0)
  );

  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    logic [8:0]  b;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Called at a negedge. Requests a conversion of b and follows it until the
  // done pulse (sampled at negedges; cycle 1 is the one after the accepting
  // edge). bin is scrambled after acceptance to show it is not re-sampled.
  task automatic run_conv(input logic [8:0] b, output int dcyc, output int bcnt,
                          output logic [11:0] dig, output int dig_chg);
    logic [11:0] held;
    dcyc    = 0;
    bcnt    = 0;
    dig     = '0;
    dig_chg = 0;
    held    = {bcd2, bcd1, bcd0};
    bin     = b;
    start   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK_50);
      start = 1'b0;
      bin   = 9'($urandom);
      if (done) begin
        dcyc = k;
        dig  = {bcd2, bcd1, bcd0};
        break;
      end
      bcnt += int'(busy);
      if ({bcd2, bcd1, bcd0} != held) dig_chg = 1;
    end
  endtask

  int          dcyc;
  int          bcnt;
  int          chg;
  logic [11:0] dig;
  logic [11:0] mdl;
  int          done_seen;
  int          first_done;
  int          busy_seen;
  int          bad_range;

  initial begin
    vecs[0]  = '{9'd0,   12'h000};
    vecs[1]  = '{9'd511, 12'h511};
    vecs[2]  = '{9'd255, 12'h255};
    vecs[3]  = '{9'd100, 12'h100};
    vecs[4]  = '{9'd1,   12'h001};
    vecs[5]  = '{9'd9,   12'h009};
    vecs[6]  = '{9'd10,  12'h010};
    vecs[7]  = '{9'd99,  12'h099};
    vecs[8]  = '{9'd256, 12'h256};
    vecs[9]  = '{9'd300, 12'h300};
    vecs[10] = '{9'd459, 12'h459};
    vecs[11] = '{9'd128, 12'h128};

    RST_N = 1'b0;
    start = 1'b0;
    bin   = '0;

    #5;
    check("reset_busy",   int'(busy), 0);
    check("reset_done",   int'(done), 0);
    check("reset_digits", int'({bcd2, bcd1, bcd0}), 0);

    @(negedge CLK_50);
    @(negedge CLK_50);
    RST_N = 1'b1;
    @(negedge CLK_50);

    // bin = 0: busy 9 cycles, done in cycle 10, digits 0/0/0
    run_conv(9'd0, dcyc, bcnt, dig, chg);
    check("zero_done_cycle", dcyc, 10);
    check("zero_busy_cycles", bcnt, 9);
    check("zero_busy_at_done", int'(busy), 0);
    check("zero_digits", int'(dig), 12'h000);
    @(negedge CLK_50);
    check("zero_done_one_cycle", int'(done), 0);

    // table of directed vectors, each started in the previous done cycle
    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].b, dcyc, bcnt, dig, chg);
      check($sformatf("vec%0d_done_cycle", i), dcyc, 10);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
      check($sformatf("vec%0d_busy_at_done", i), int'(busy), 0);
      check($sformatf("vec%0d_digits_held", i), chg, 0);
      check($sformatf("vec%0d_digits", i), int'(dig), int'(vecs[i].exp));
    end

    // back-to-back 255 then 100, second start in the done cycle
    @(negedge CLK_50);
    run_conv(9'd255, dcyc, bcnt, dig, chg);
    check("b2b_first_digits", int'(dig), 12'h255);
    run_conv(9'd100, dcyc, bcnt, dig, chg);
    check("b2b_spacing", dcyc, 10);
    check("b2b_second_digits", int'(dig), 12'h100);

    // 37 started, start with 400 pulsed at cycle 4 must be ignored
    @(negedge CLK_50);
    bin        = 9'd37;
    start      = 1'b1;
    done_seen  = 0;
    first_done = 0;
    dig        = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge CLK_50);
      if (k == 4) begin
        start = 1'b1;
        bin   = 9'd400;
      end else begin
        start = 1'b0;
        bin   = 9'd0;
      end
      if (done) begin
        done_seen++;
        if (first_done == 0) begin
          first_done = k;
          dig        = {bcd2, bcd1, bcd0};
        end
      end
    end
    check("ignore_done_count", done_seen, 1);
    check("ignore_done_cycle", first_done, 10);
    check("ignore_digits", int'(dig), 12'h037);
    check("ignore_idle_after", int'(busy), 0);

    // reset during cycle 5 of a 499 conversion
    bin   = 9'd499;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK_50);
      start = 1'b0;
    end
    check("abort_busy_before", int'(busy), 1);
    RST_N = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_digits", int'({bcd2, bcd1, bcd0}), 0);
    @(negedge CLK_50);
    RST_N     = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK_50);
      done_seen += int'(done);
      busy_seen += int'(busy);
    end
    check("abort_no_done", done_seen, 0);
    check("abort_no_busy", busy_seen, 0);
    run_conv(9'd499, dcyc, bcnt, dig, chg);
    check("abort_rerun_cycle", dcyc, 10);
    check("abort_rerun_digits", int'(dig), 12'h499);

    // start held as reset releases is taken on the first edge
    @(negedge CLK_50);
    RST_N = 1'b0;
    @(negedge CLK_50);
    RST_N = 1'b1;
    run_conv(9'd123, dcyc, bcnt, dig, chg);
    check("release_start_cycle", dcyc, 10);
    check("release_start_digits", int'(dig), 12'h123);

    // exhaustive sweep against a decimal model
    bad_range = 0;
    for (int v = 0; v < 512; v++) begin
      run_conv(9'(v), dcyc, bcnt, dig, chg);
      mdl = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      check($sformatf("sweep_%0d", v), int'(dig), int'(mdl));
      if (dig[11:8] > 4'd5 || dig[7:4] > 4'd9 || dig[3:0] > 4'd9) bad_range++;
    end
    check("sweep_digit_range", bad_range, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
